hazard_ctrl: RTL and testbench

- Hazard and forwarding controller for the 3-stage F/D/E RV32 pipeline; it is the producer of the forwarding selects, stalls and flushes that the datapath muxes consume.
- Tracks the E-stage destination in its own shadow register and generates for_A/for_B.
- Detects load-use and PC-link hazards, stalls the pipeline on data-memory wait states, and squashes the wrong path on taken branches.

---
 rtl/hazard_ctrl.sv | 169 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and forwarding controller for the F/D/E RV32 pipeline.
// Latency: for_A/for_B/stall/flush_D/mem_req are combinational from the E shadow and D inputs.
//          mem_err and the perf counters are registered.
// Backpressure: a pending data-memory access holds the whole pipeline (stall, E shadow held)
//               until mem_ready or a MAX_WAIT timeout. A taken branch flushes D and bubbles E.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   valid_D .. mem_op_D       decoded fields of the instruction sitting in D
//   br_taken, mem_ready       E-stage branch resolution and data-memory completion
//   for_A, for_B              select Alu_out_E onto operand A / B
//   stall, flush_D            hold PC + F/D, clear F/D at next edge
//   mem_req, mem_err          E access outstanding, sticky timeout flag
//   perf_stall_cnt/flush_cnt  event counters, present only when HAZARD_PERF_EN is defined
//
// Optional build macro: HAZARD_PERF_EN (default undefined: counter ports read 0, no counter flops).

module hazard_ctrl #(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned XLEN_REG = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_D,
    input  logic [XLEN_REG-1:0] rs1_D,
    input  logic [XLEN_REG-1:0] rs2_D,
    input  logic                use_rs1_D,
    input  logic                use_rs2_D,
    input  logic [XLEN_REG-1:0] rd_D,
    input  logic                reg_wr_D,
    input  logic [1:0]          wb_sel_D,
    input  logic                mem_op_D,
    input  logic                br_taken,
    input  logic                mem_ready,
    output logic                for_A,
    output logic                for_B,
    output logic                stall,
    output logic                flush_D,
    output logic                mem_req,
    output logic                mem_err,
    output logic [31:0]         perf_stall_cnt,
    output logic [31:0]         perf_flush_cnt
);

    typedef enum logic [0:0] {RUN, MEM_WAIT} state_t;

    typedef struct packed {
        logic                valid;
        logic [XLEN_REG-1:0] rd;
        logic                reg_wr;
        logic [1:0]          wb_sel;
        logic                mem_op;
    } shadow_t;

    // The wait counter holds how many mem_ready-low cycles the current E access has
    // already spent, so the timeout fires on the MAX_WAIT-th consecutive low cycle.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t     state_q;
    logic [7:0] wait_cnt_q;
    logic       mem_err_q;
    shadow_t    shadow_q, shadow_d;

    logic match_a, match_b, alu_e, e_mem, data_haz;
    logic timeout_now, mem_wait_active, stall_raw, flush_raw;

    assign match_a = valid_D & shadow_q.valid & shadow_q.reg_wr & (shadow_q.rd != '0)
                   & use_rs1_D & (shadow_q.rd == rs1_D);
    assign match_b = valid_D & shadow_q.valid & shadow_q.reg_wr & (shadow_q.rd != '0)
                   & use_rs2_D & (shadow_q.rd == rs2_D);
    assign alu_e   = (shadow_q.wb_sel == 2'b00);
    assign e_mem   = shadow_q.valid & shadow_q.mem_op;

    // Load or PC-link result is not ready for forwarding; the register file writes at the
    // end of E, so one bubble is enough.
    assign data_haz = (match_a | match_b) & ~alu_e;

    assign timeout_now     = e_mem & ~mem_ready & (wait_cnt_q == WAIT_LAST);
    assign mem_wait_active = e_mem & ~mem_ready & ~timeout_now;

    assign stall_raw = mem_wait_active | (data_haz & ~br_taken);
    assign flush_raw = br_taken & ~mem_wait_active;

    // Outputs drop in the very cycle rst is sampled, not one cycle later.
    assign for_A   = ~rst & match_a & alu_e;
    assign for_B   = ~rst & match_b & alu_e;
    assign stall   = ~rst & stall_raw;
    assign flush_D = ~rst & flush_raw;
    assign mem_req = ~rst & mem_wait_active;
    assign mem_err = ~rst & mem_err_q;

    // E shadow next state: memory wait holds, branch or load-use inserts a bubble.
    always_comb begin
        shadow_d = shadow_q;
        if (mem_wait_active) begin
            shadow_d = shadow_q;
        end else if (br_taken | data_haz) begin
            shadow_d = '0;
        end else begin
            shadow_d.valid  = valid_D;
            shadow_d.rd     = rd_D;
            shadow_d.reg_wr = reg_wr_D;
            shadow_d.wb_sel = wb_sel_D;
            shadow_d.mem_op = mem_op_D;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
            shadow_q   <= '0;
        end else begin
            shadow_q <= shadow_d;
            if (timeout_now) begin
                mem_err_q <= 1'b1;
            end
            case (state_q)
                RUN: begin
                    if (mem_wait_active) begin
                        state_q    <= MEM_WAIT;
                        wait_cnt_q <= 8'd1;
                    end else begin
                        wait_cnt_q <= '0;
                    end
                end
                MEM_WAIT: begin
                    // Leaves on mem_ready or timeout; both release E as a completion.
                    if (mem_wait_active) begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end else begin
                        state_q    <= RUN;
                        wait_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q    <= RUN;
                    wait_cnt_q <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q, perf_flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (stall_raw) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (flush_raw) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = rst ? '0 : perf_stall_q;
    assign perf_flush_cnt = rst ? '0 : perf_flush_q;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl (MAX_WAIT = 4).
// Driver applies one D/E input set per cycle and queues the reference-model response;
// a monitor on the falling edge pops and compares every cycle's outputs.

module tb_hazard_ctrl;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_D;
    logic [4:0]  rs1_D, rs2_D, rd_D;
    logic        use_rs1_D, use_rs2_D, reg_wr_D, mem_op_D;
    logic [1:0]  wb_sel_D;
    logic        br_taken, mem_ready;
    logic        for_A, for_B, stall, flush_D, mem_req, mem_err;
    logic [31:0] perf_stall_cnt, perf_flush_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.MAX_WAIT(MAXW), .XLEN_REG(5)) dut (
        .clk(clk), .rst(rst),
        .valid_D(valid_D), .rs1_D(rs1_D), .rs2_D(rs2_D),
        .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D),
        .rd_D(rd_D), .reg_wr_D(reg_wr_D), .wb_sel_D(wb_sel_D), .mem_op_D(mem_op_D),
        .br_taken(br_taken), .mem_ready(mem_ready),
        .for_A(for_A), .for_B(for_B), .stall(stall), .flush_D(flush_D),
        .mem_req(mem_req), .mem_err(mem_err),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    typedef struct packed {
        logic        fa;
        logic        fb;
        logic        st;
        logic        fl;
        logic        rq;
        logic        er;
        logic [31:0] ps;
        logic [31:0] pf;
    } exp_t;

    exp_t  exp_q[$];
    string lbl_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    // Reference model: the instruction currently in E, how long it has waited, and counters.
    bit          m_valid, m_rw, m_mo, m_err;
    logic [4:0]  m_rd;
    logic [1:0]  m_wb;
    int          m_low;
    bit   [31:0] m_ps, m_pf;

    task automatic step(input string lbl, input bit r, input bit v,
                        input logic [4:0] s1, input logic [4:0] s2, input bit u1, input bit u2,
                        input logic [4:0] rd, input bit rw, input logic [1:0] wb, input bit mo,
                        input bit br, input bit mr);
        exp_t e;
        bit ma, mb, haz, pend, tmo, wact, stl, fl;
        @(posedge clk);
        #1;
        rst = r; valid_D = v; rs1_D = s1; rs2_D = s2; use_rs1_D = u1; use_rs2_D = u2;
        rd_D = rd; reg_wr_D = rw; wb_sel_D = wb; mem_op_D = mo; br_taken = br; mem_ready = mr;
        e = '0;
        if (r) begin
            m_valid = 0; m_rw = 0; m_mo = 0; m_err = 0; m_rd = '0; m_wb = '0;
            m_low = 0; m_ps = 0; m_pf = 0;
        end else begin
            ma   = v && m_valid && m_rw && (m_rd != 0) && u1 && (m_rd == s1);
            mb   = v && m_valid && m_rw && (m_rd != 0) && u2 && (m_rd == s2);
            haz  = (ma || mb) && (m_wb != 2'b00);
            pend = m_valid && m_mo && !mr;
            tmo  = pend && (m_low + 1 == MAXW);
            wact = pend && !tmo;
            stl  = wact || (haz && !br);
            fl   = br && !wact;
            e.fa = ma && (m_wb == 2'b00);
            e.fb = mb && (m_wb == 2'b00);
            e.st = stl;
            e.fl = fl;
            e.rq = m_valid && m_mo && !(mr || tmo);
            e.er = m_err;
`ifdef HAZARD_PERF_EN
            e.ps = m_ps;
            e.pf = m_pf;
`endif
            if (stl) m_ps = m_ps + 1;
            if (fl)  m_pf = m_pf + 1;
            if (tmo) m_err = 1;
            if (wact) begin
                m_low = m_low + 1;
            end else begin
                m_low = 0;
                if (br || haz) begin
                    m_valid = 0; m_rw = 0; m_mo = 0; m_rd = '0; m_wb = '0;
                end else begin
                    m_valid = v; m_rw = rw; m_mo = mo; m_rd = rd; m_wb = wb;
                end
            end
        end
        exp_q.push_back(e);
        lbl_q.push_back(lbl);
    endtask

    task automatic dcyc(input string lbl, input bit v,
                        input logic [4:0] s1, input logic [4:0] s2, input bit u1, input bit u2,
                        input logic [4:0] rd, input bit rw, input logic [1:0] wb, input bit mo,
                        input bit br, input bit mr);
        step(lbl, 1'b0, v, s1, s2, u1, u2, rd, rw, wb, mo, br, mr);
    endtask

    // Monitor: compare every cycle on the falling edge, away from the sampling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t  e;
                exp_t  got;
                string l;
                e   = exp_q.pop_front();
                l   = lbl_q.pop_front();
                got = {for_A, for_B, stall, flush_D, mem_req, mem_err, perf_stall_cnt, perf_flush_cnt};
                n_tests++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL %s t=%0t: got fA=%0b fB=%0b st=%0b fl=%0b rq=%0b er=%0b ps=%0d pf=%0d, want fA=%0b fB=%0b st=%0b fl=%0b rq=%0b er=%0b ps=%0d pf=%0d",
                             l, $time, got.fa, got.fb, got.st, got.fl, got.rq, got.er, got.ps, got.pf,
                             e.fa, e.fb, e.st, e.fl, e.rq, e.er, e.ps, e.pf);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; valid_D = 0; rs1_D = '0; rs2_D = '0; use_rs1_D = 0; use_rs2_D = 0;
        rd_D = '0; reg_wr_D = 0; wb_sel_D = '0; mem_op_D = 0; br_taken = 0; mem_ready = 1;

        step("reset", 1, 1, 5'd1, 5'd1, 1, 1, 5'd1, 1, 2'd0, 0, 1, 0);
        step("reset", 1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 1);

        // ALU forwarding, then the same pattern with rd = 0.
        dcyc("alu_prod", 1, 0, 0, 0, 0, 5'd5, 1, 2'b00, 0, 0, 1);
        dcyc("alu_fwd",  1, 5'd5, 5'd5, 1, 1, 5'd0, 0, 2'b00, 0, 0, 1);
        dcyc("rd0_prod", 1, 0, 0, 0, 0, 5'd0, 1, 2'b00, 0, 0, 1);
        dcyc("rd0_fwd",  1, 5'd0, 5'd0, 1, 1, 5'd0, 0, 2'b00, 0, 0, 1);

        // Load-use: one stall, then E is a bubble.
        dcyc("ld_prod", 1, 0, 0, 0, 0, 5'd7, 1, 2'b01, 1, 0, 1);
        dcyc("ld_use",  1, 5'd0, 5'd7, 0, 1, 5'd0, 0, 2'b00, 0, 0, 1);
        dcyc("ld_use2", 1, 5'd0, 5'd7, 0, 1, 5'd0, 0, 2'b00, 0, 0, 1);

        // Memory wait: three low cycles, then completion.
        dcyc("mw_prod", 1, 0, 0, 0, 0, 5'd8, 1, 2'b01, 1, 0, 1);
        for (int i = 0; i < 3; i++) dcyc("mw_wait", 1, 0, 0, 0, 0, 5'd3, 1, 2'b00, 0, 0, 0);
        dcyc("mw_done", 1, 0, 0, 0, 0, 5'd3, 1, 2'b00, 0, 0, 1);

        // Timeout: mem_ready never rises; mem_err must stick afterwards.
        dcyc("to_prod", 1, 0, 0, 0, 0, 5'd9, 1, 2'b01, 1, 0, 1);
        for (int i = 0; i < 6; i++) dcyc("to_wait", 1, 0, 0, 0, 0, 5'd4, 1, 2'b00, 0, 0, 0);
        for (int i = 0; i < 3; i++) dcyc("to_sticky", 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1);

        // Branch wins over a load-use hazard.
        dcyc("br_prod",  1, 0, 0, 0, 0, 5'd9, 1, 2'b01, 1, 0, 1);
        dcyc("br_haz",   1, 5'd9, 5'd0, 1, 0, 5'd0, 0, 2'b00, 0, 1, 1);
        dcyc("br_after", 1, 5'd9, 5'd0, 1, 0, 5'd0, 0, 2'b00, 0, 0, 1);

        // PC+4 writeback in E also forces a stall.
        dcyc("pc_prod", 1, 0, 0, 0, 0, 5'd1, 1, 2'b10, 0, 0, 1);
        dcyc("pc_use",  1, 5'd1, 5'd1, 1, 1, 5'd0, 0, 2'b00, 0, 0, 1);

        // Reset in the middle of a memory wait.
        dcyc("rw_prod", 1, 0, 0, 0, 0, 5'd6, 1, 2'b01, 1, 0, 1);
        dcyc("rw_wait", 1, 5'd6, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0);
        dcyc("rw_wait", 1, 5'd6, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0);
        step("rw_rst",  1, 1, 5'd6, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0);
        dcyc("rw_post", 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);

        // Randomized traffic with small register indices so matches are frequent.
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] wb;
            bit         mo;
            wb = 2'($urandom_range(0, 2));
            mo = (wb == 2'b01) || ($urandom_range(0, 5) == 0);
            step("rand", ($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), wb, mo,
                 ($urandom_range(0, 6) == 0), ($urandom_range(0, 3) != 0));
        end

        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d responses left unchecked, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
